glyph_ram_loader: RTL and testbench

- Writer side of the character generator's glyph store. Accepts font bytes from the host download interface and buffers them in a small FIFO.
- Commits each byte into the 4K glyph RAM through a write port the character generator shares. The loader uses that port only when the generator grants the slot.
- Reads every byte back and compares it, then reports completion and error status to the host.

---
 rtl/glyph_ram_loader.sv | 152 +++++++++++++++
 tb/tb_glyph_ram_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_ram_loader.sv
// Glyph RAM writer: buffers host font bytes in a small FIFO, commits each one
// through the shared RAM port during granted slots, reads it back and verifies it.
module glyph_ram_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_ready,
  input  logic              slot_ok,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   wr_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  // Font files are MSB-left; the shifter consumes LSB first.
  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count, count_next;

  logic [2:0]        state, state_next;
  logic [ADDR_W-1:0] hold_addr, hold_addr_next;
  logic [DATA_W-1:0] hold_data, hold_data_next;
  logic              error_next;
  logic [WC_W-1:0]   wr_count_next;
  logic              active_q;

  logic full, fire, accept, overflow;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign head_addr = fifo_addr[rptr];
  assign head_data = fifo_data[rptr];
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign fire      = !reset && (state == S_LOAD) && (count != '0) && slot_ok;
  assign accept    = (state != S_IDLE) && dl_wr && (!full || fire);
  assign overflow  = (state != S_IDLE) && dl_wr && full && !fire;

  // The shared port is only driven with a write while the slot is granted.
  assign ram_we   = fire;
  assign ram_addr = reset ? '0 : (fire ? head_addr : hold_addr);
  assign ram_data = reset ? '0 : (fire ? head_data : hold_data);

  always_comb begin
    count_next = count;
    if (accept && !fire)      count_next = count + CNT_W'(1);
    else if (fire && !accept) count_next = count - CNT_W'(1);
  end

  always_comb begin
    state_next     = state;
    hold_addr_next = hold_addr;
    hold_data_next = hold_data;
    error_next     = error | overflow;
    wr_count_next  = wr_count;
    case (state)
      S_IDLE: begin
        if (dl_active && !active_q) begin
          error_next    = 1'b0;
          wr_count_next = '0;
          state_next    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fire) begin
          hold_addr_next = head_addr;
          hold_data_next = head_data;
          state_next     = S_WRITE;
        end else if (!dl_active && (count == '0)) begin
          state_next = S_FIN;
        end
      end
      S_WRITE: if (slot_ok) state_next = S_READ;
      S_READ:  state_next = S_CHECK;
      S_CHECK: begin
        if (ram_q != hold_data)  error_next    = 1'b1;
        else if (wr_count != '1) wr_count_next = wr_count + WC_W'(1);
        state_next = S_LOAD;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      error     <= 1'b0;
      wr_count  <= '0;
      done      <= 1'b0;
      dl_ready  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      hold_addr <= hold_addr_next;
      hold_data <= hold_data_next;
      error     <= error_next;
      wr_count  <= wr_count_next;
      done      <= (state_next == S_FIN);
      dl_ready  <= (count_next != CNT_W'(FIFO_DEPTH));
      active_q  <= dl_active;
      if (accept) wptr <= wptr + PTR_W'(1);
      if (fire)   rptr <= rptr + PTR_W'(1);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge pixel_clock) begin
    if (accept) begin
      fifo_addr[wptr] <= dl_addr;
      fifo_data[wptr] <= xform(dl_data);
    end
  end

endmodule

// File: tb/tb_glyph_ram_loader.sv
// Bench for glyph_ram_loader: two instances (bit-reversed and plain) share the
// host stimulus; each has its own glyph RAM model and write scoreboard.
module tb_glyph_ram_loader;

  logic        pixel_clock;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [11:0] dl_addr;
  logic [7:0]  dl_data;
  logic        slot_ok;

  logic        dl_ready, ram_we, done, error;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data, ram_q;
  logic [12:0] wr_count;

  logic        dl_ready0, ram_we0, done0, error0;
  logic [11:0] ram_addr0;
  logic [7:0]  ram_data0, ram_q0;
  logic [12:0] wr_count0;

  glyph_ram_loader #(.ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(4), .BIT_REVERSE(1)) dut (
    .pixel_clock(pixel_clock), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready), .slot_ok(slot_ok),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .done(done), .error(error), .wr_count(wr_count)
  );

  glyph_ram_loader #(.ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(4), .BIT_REVERSE(0)) dut0 (
    .pixel_clock(pixel_clock), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready0), .slot_ok(slot_ok),
    .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_q(ram_q0),
    .done(done0), .error(error0), .wr_count(wr_count0)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  // Synchronous RAM models; address 0x7FF reads back corrupted as 0x00.
  logic [7:0] mem  [4096];
  logic [7:0] mem0 [4096];
  always @(posedge pixel_clock) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= (ram_addr == 12'h7FF) ? 8'h00 : mem[ram_addr];
  end
  always @(posedge pixel_clock) begin
    if (ram_we0) mem0[ram_addr0] <= ram_data0;
    ram_q0 <= (ram_addr0 == 12'h7FF) ? 8'h00 : mem0[ram_addr0];
  end

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rev;
    logic [7:0]  exp_plain;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  q1[$];
  wr_t  q0[$];
  int   n_cmp;
  int   n_bad;
  int   done_cnt;
  bit   gate_mode;
  int   phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = d[i];
    return r;
  endfunction

  // Write scoreboard: every committed write must match the head of the queue.
  task automatic mon();
    wr_t e;
    if (!reset) begin
      if (ram_we) begin
        chk("we_in_slot", 32'(slot_ok), 32'd1);
        n_cmp++;
        if (q1.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none", ram_addr, ram_data);
        end else begin
          e = q1.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.addr));
          chk("wr_data", 32'(ram_data), 32'(e.data));
        end
      end
      if (ram_we0) begin
        chk("we0_in_slot", 32'(slot_ok), 32'd1);
        n_cmp++;
        if (q0.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write0: got addr 0x%0h data 0x%0h, want none", ram_addr0, ram_data0);
        end else begin
          e = q0.pop_front();
          chk("wr0_addr", 32'(ram_addr0), 32'(e.addr));
          chk("wr0_data", 32'(ram_data0), 32'(e.data));
        end
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge pixel_clock);
    mon();
    @(posedge pixel_clock);
    #1;
    if (gate_mode) begin
      slot_ok = (phase == 0);
      phase   = (phase + 1) % 4;
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [7:0] d,
                      input logic [7:0] er, input logic [7:0] ep, input bit expect_wr);
    wr_t e;
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    if (expect_wr) begin
      e.addr = a; e.data = er; q1.push_back(e);
      e.data = ep; q0.push_back(e);
    end
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic start_session();
    dl_active = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_session(input int budget, input int exp_cnt, input bit exp_err);
    bit found;
    found = 1'b0;
    dl_active = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    chk("done_pulse", 32'(found), 32'd1);
    chk("wr_count", 32'(wr_count), 32'(exp_cnt));
    chk("error", 32'(error), 32'(exp_err));
    chk("sb_drained", 32'(q1.size()), 32'd0);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    tick();
  endtask

  vec_t vecs[5];
  int   done_before;

  initial begin
    vecs[0] = '{12'h041, 8'h01, 8'h80, 8'h01};
    vecs[1] = '{12'h000, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{12'hFFF, 8'hF0, 8'h0F, 8'hF0};
    vecs[3] = '{12'h123, 8'h12, 8'h48, 8'h12};
    vecs[4] = '{12'h7FE, 8'h6E, 8'h76, 8'h6E};

    n_cmp = 0; n_bad = 0; done_cnt = 0; gate_mode = 1'b0; phase = 0;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0; slot_ok = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_dl_ready", 32'(dl_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 32'(dl_ready), 32'd1);

    // Single-byte sessions from the vector table, both bit orders
    slot_ok = 1'b1;
    for (int v = 0; v < 5; v++) begin
      start_session();
      chk("sess_err_clear", 32'(error), 32'd0);
      push(vecs[v].addr, vecs[v].data, vecs[v].exp_rev, vecs[v].exp_plain, 1'b1);
      end_session(100, 1, 1'b0);
      chk("plain_wr_count", 32'(wr_count0), 32'd1);
      chk("plain_error", 32'(error0), 32'd0);
    end

    // Slot gating: one granted cycle in four, four back-to-back pushes
    start_session();
    gate_mode = 1'b1; phase = 1; slot_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'(8'h01 << k);
      push(12'h300 + 12'(k), d, rev8(d), d, 1'b1);
    end
    end_session(300, 4, 1'b0);
    gate_mode = 1'b0;
    slot_ok = 1'b1;

    // Overflow: no grants while five bytes arrive
    start_session();
    slot_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ready_before_full", 32'(dl_ready), 32'd1);
      push(12'h400 + 12'(k), 8'(8'h10 + k), rev8(8'(8'h10 + k)), 8'(8'h10 + k), 1'b1);
    end
    chk("ready_full", 32'(dl_ready), 32'd0);
    chk("err_before_ovf", 32'(error), 32'd0);
    push(12'h404, 8'h55, 8'h00, 8'h00, 1'b0);
    chk("err_ovf", 32'(error), 32'd1);
    slot_ok = 1'b1;
    end_session(200, 4, 1'b1);

    // Readback mismatch at 0x7FF
    start_session();
    chk("err_cleared_by_rise", 32'(error), 32'd0);
    push(12'h7FF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    push(12'h100, 8'h3C, 8'h3C, 8'h3C, 1'b1);
    end_session(200, 1, 1'b1);
    tick(); tick(); tick();
    chk("err_sticky_idle", 32'(error), 32'd1);

    // Reset in the cycle after a write with a second byte queued
    start_session();
    chk("err_cleared_again", 32'(error), 32'd0);
    slot_ok = 1'b0;
    push(12'h010, 8'h11, rev8(8'h11), 8'h11, 1'b1);
    push(12'h011, 8'h22, rev8(8'h22), 8'h22, 1'b1);
    slot_ok = 1'b1;
    tick();
    chk("first_written", 32'(q1.size()), 32'd1);
    reset = 1'b1;
    dl_active = 1'b0;
    q1.delete();
    q0.delete();
    chk("rst_cycle_we", 32'(ram_we), 32'd0);
    done_before = done_cnt;
    tick();
    chk("rst_mid_we", 32'(ram_we), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_we", 32'(ram_we), 32'd0);
    chk("post_rst_ready", 32'(dl_ready), 32'd1);
    chk("post_rst_count", 32'(wr_count), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("no_done_after_rst", 32'(done_cnt), 32'(done_before));
    chk("idle_no_write", 32'(ram_we), 32'd0);

    // Fresh session after reset
    start_session();
    push(12'h200, 8'h0F, 8'hF0, 8'h0F, 1'b1);
    end_session(100, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
